// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// PipeStageElastic
//
// Elastic register chain that carries an opaque WIDTH-bit payload between two
// core pipeline stages with a valid/ready handshake. The chain holds DEPTH
// register stages. With SKID=1 each stage pairs a main register with a skid
// register, so every stage ready is a flop output and no combinational path
// runs from out_ready to in_ready. With SKID=0 each stage is a single register
// and ready ripples combinationally back through the chain. With BYPASS=1 the
// block is a plain wire.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream payload valid
//   in_ready   block accepts the payload this cycle
//   in_data    upstream payload
//   out_valid  payload available downstream
//   out_ready  downstream accepts the payload
//   out_data   downstream payload, BUBBLE_VALUE whenever out_valid is low
//   hold       pause: freeze all state and block both handshakes
//   flush      discard every held payload at the next edge (beats hold)
//   occupancy  number of payloads currently held
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int                 WIDTH        = 32,
    parameter int                 DEPTH        = 1,
    parameter int                 SKID         = 1,
    parameter int                 BYPASS       = 0,
    parameter logic [WIDTH-1:0]   BUBBLE_VALUE = '0
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [WIDTH-1:0]                          in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [WIDTH-1:0]                          out_data,
    input  logic                                      hold,
    input  logic                                      flush,
    output logic [$clog2(DEPTH*(1+SKID)+1)-1:0]       occupancy
);

    localparam int CAPACITY = DEPTH * (1 + SKID);
    localparam int OCC_W    = $clog2(CAPACITY + 1);

    generate
        if (BYPASS != 0) begin : genBypass

            // Pure pass-through: the clock, reset, hold and flush have no
            // effect here. They are folded into a deliberately unused net.
            logic unusedBypassInputs;
            assign unusedBypassInputs = ^{clock, reset, hold, flush};

            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_valid ? in_data : BUBBLE_VALUE;
            assign occupancy = '0;

        end else begin : genChain

            // Per-stage state. Stage 0 faces the upstream port.
            // Stage DEPTH-1 faces the downstream port.
            logic [DEPTH-1:0] mainValid_q;
            logic [DEPTH-1:0] mainValid_d;
            logic [DEPTH-1:0] skidValid_q;
            logic [DEPTH-1:0] skidValid_d;
            logic [WIDTH-1:0] mainData_q [DEPTH];
            logic [WIDTH-1:0] mainData_d [DEPTH];
            logic [WIDTH-1:0] skidData_q [DEPTH];
            logic [WIDTH-1:0] skidData_d [DEPTH];
            logic [OCC_W-1:0] occ_q;
            logic [OCC_W-1:0] occ_d;

            // stageReady[i] is the ready that stage i shows to its upstream.
            // stageReady[DEPTH] is the downstream ready seen by the last stage.
            logic [DEPTH:0]   stageReady;
            logic [DEPTH-1:0] pushStage;
            logic [DEPTH-1:0] popStage;
            logic [WIDTH-1:0] upData [DEPTH];

            logic active;
            logic outReadyEff;
            logic accept;
            logic deliver;

            // While hold or flush is high, both external handshakes are
            // blocked. The last stage then sees a downstream ready of 0.
            assign active      = ~hold & ~flush;
            assign outReadyEff = out_ready & active;

            // Ready chain, walked from the output back to the input.
            // A skid stage's ready comes only from its own skid flag.
            // A single-register stage is ready when it is empty or when
            // the stage downstream takes its payload.
            always_comb begin
                logic downReady;
                logic rdy;
                stageReady        = '0;
                stageReady[DEPTH] = outReadyEff;
                downReady         = outReadyEff;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (SKID != 0) begin
                        rdy = ~skidValid_q[i];
                    end else begin
                        rdy = ~mainValid_q[i] | downReady;
                    end
                    stageReady[i] = rdy;
                    downReady     = rdy;
                end
            end

            // External handshakes. in_ready stays low during reset, so no
            // transfer can happen before the first edge after release.
            assign in_ready  = ~reset & active & stageReady[0];
            assign out_valid = mainValid_q[DEPTH-1] & active;
            assign out_data  = out_valid ? mainData_q[DEPTH-1] : BUBBLE_VALUE;
            assign accept    = in_valid & in_ready;
            assign deliver   = out_valid & out_ready;
            assign occupancy = occ_q;

            // Work out the push into each stage and the pop out of it.
            // Stage 0 is fed by the external accept.
            // Each later stage is fed by the main register of the stage
            // before it.
            always_comb begin
                pushStage = '0;
                popStage  = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    upData[i] = BUBBLE_VALUE;
                end
                pushStage[0] = accept;
                upData[0]    = in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    pushStage[i] = mainValid_q[i-1] & stageReady[i];
                    upData[i]    = mainData_q[i-1];
                end
                for (int i = 0; i < DEPTH; i++) begin
                    popStage[i] = mainValid_q[i] & stageReady[i+1];
                end
            end

            // Next-state logic for every stage and for the occupancy count.
            // Flush clears everything and overrides hold. Hold freezes all
            // state. Otherwise each stage follows its own push and pop.
            // Skid stage: a held skid payload moves into main on a pop.
            // A push lands in main if main is free or is draining this
            // cycle, and lands in skid otherwise.
            always_comb begin
                mainValid_d = mainValid_q;
                skidValid_d = skidValid_q;
                mainData_d  = mainData_q;
                skidData_d  = skidData_q;
                occ_d       = occ_q;

                if (flush) begin
                    mainValid_d = '0;
                    skidValid_d = '0;
                    occ_d       = '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mainData_d[i] = BUBBLE_VALUE;
                        skidData_d[i] = BUBBLE_VALUE;
                    end
                end else if (!hold) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (SKID != 0) begin
                            if (skidValid_q[i]) begin
                                if (popStage[i]) begin
                                    mainData_d[i]  = skidData_q[i];
                                    skidValid_d[i] = 1'b0;
                                    skidData_d[i]  = BUBBLE_VALUE;
                                end
                            end else if (pushStage[i]) begin
                                if (!mainValid_q[i] || popStage[i]) begin
                                    mainValid_d[i] = 1'b1;
                                    mainData_d[i]  = upData[i];
                                end else begin
                                    skidValid_d[i] = 1'b1;
                                    skidData_d[i]  = upData[i];
                                end
                            end else if (popStage[i]) begin
                                mainValid_d[i] = 1'b0;
                                mainData_d[i]  = BUBBLE_VALUE;
                            end
                        end else begin
                            if (popStage[i] || !mainValid_q[i]) begin
                                mainValid_d[i] = pushStage[i];
                                mainData_d[i]  = pushStage[i] ? upData[i] : BUBBLE_VALUE;
                            end
                        end
                    end

                    case ({accept, deliver})
                        2'b10:   occ_d = occ_q + OCC_W'(1);
                        2'b01:   occ_d = occ_q - OCC_W'(1);
                        default: occ_d = occ_q;
                    endcase
                end
            end

            // State registers. On reset every payload slot goes back to
            // the bubble encoding and the chain is empty.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mainValid_q <= '0;
                    skidValid_q <= '0;
                    occ_q       <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mainData_q[i] <= BUBBLE_VALUE;
                        skidData_q[i] <= BUBBLE_VALUE;
                    end
                end else begin
                    mainValid_q <= mainValid_d;
                    skidValid_q <= skidValid_d;
                    occ_q       <= occ_d;
                    for (int i = 0; i < DEPTH; i++) begin
                        mainData_q[i] <= mainData_d[i];
                        skidData_q[i] <= skidData_d[i];
                    end
                end
            end

        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_stage_elastic. Four instances are used:
//   A: DEPTH=3, SKID=1
//   B: DEPTH=1, SKID=1
//   C: DEPTH=2, SKID=0
//   D: BYPASS=1
// Expected payloads are queued when the stimulus issues them. A monitor
// per instance pops a payload on every delivery and compares it.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int         W      = 16;
    localparam logic [W-1:0] BUBBLE = 16'h0013;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic         aInValid, aInReady, aOutValid, aOutReady, aHold, aFlush;
    logic [W-1:0] aInData, aOutData;
    logic [2:0]   aOcc;

    logic         bInValid, bInReady, bOutValid, bOutReady, bHold, bFlush;
    logic [W-1:0] bInData, bOutData;
    logic [1:0]   bOcc;

    logic         cInValid, cInReady, cOutValid, cOutReady, cHold, cFlush;
    logic [W-1:0] cInData, cOutData;
    logic [1:0]   cOcc;

    logic         dInValid, dInReady, dOutValid, dOutReady, dHold, dFlush;
    logic [W-1:0] dInData, dOutData;
    logic [1:0]   dOcc;

    logic [W-1:0] aExp[$];
    logic [W-1:0] bExp[$];
    logic [W-1:0] cExp[$];

    pipe_stage_elastic #(.WIDTH(W), .DEPTH(3), .SKID(1), .BYPASS(0), .BUBBLE_VALUE(BUBBLE)) dutA (
        .clock(clock), .reset(reset), .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .hold(aHold), .flush(aFlush), .occupancy(aOcc));

    pipe_stage_elastic #(.WIDTH(W), .DEPTH(1), .SKID(1), .BYPASS(0), .BUBBLE_VALUE(BUBBLE)) dutB (
        .clock(clock), .reset(reset), .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .hold(bHold), .flush(bFlush), .occupancy(bOcc));

    pipe_stage_elastic #(.WIDTH(W), .DEPTH(2), .SKID(0), .BYPASS(0), .BUBBLE_VALUE(BUBBLE)) dutC (
        .clock(clock), .reset(reset), .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
        .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
        .hold(cHold), .flush(cFlush), .occupancy(cOcc));

    pipe_stage_elastic #(.WIDTH(W), .DEPTH(1), .SKID(1), .BYPASS(1), .BUBBLE_VALUE(BUBBLE)) dutD (
        .clock(clock), .reset(reset), .in_valid(dInValid), .in_ready(dInReady), .in_data(dInData),
        .out_valid(dOutValid), .out_ready(dOutReady), .out_data(dOutData),
        .hold(dHold), .flush(dFlush), .occupancy(dOcc));

    // Compares one value and reports a failure with actual and required values.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Advances to just after the next rising edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // Monitors sample on the falling edge, well away from the active edge.
    // A delivery pops the oldest expected payload. An idle output must show
    // the bubble encoding.
    always @(negedge clock) begin
        if (!aOutValid) begin
            checkOutput("A idle bubble", 32'(aOutData), 32'(BUBBLE));
        end else if (aOutReady) begin
            if (aExp.size() == 0) checkOutput("A delivery with empty scoreboard", 32'(aExp.size()), 1);
            else                  checkOutput("A delivered payload", 32'(aOutData), 32'(aExp.pop_front()));
        end
    end

    always @(negedge clock) begin
        if (!bOutValid) begin
            checkOutput("B idle bubble", 32'(bOutData), 32'(BUBBLE));
        end else if (bOutReady) begin
            if (bExp.size() == 0) checkOutput("B delivery with empty scoreboard", 32'(bExp.size()), 1);
            else                  checkOutput("B delivered payload", 32'(bOutData), 32'(bExp.pop_front()));
        end
    end

    always @(negedge clock) begin
        if (!cOutValid) begin
            checkOutput("C idle bubble", 32'(cOutData), 32'(BUBBLE));
        end else if (cOutReady) begin
            if (cExp.size() == 0) checkOutput("C delivery with empty scoreboard", 32'(cExp.size()), 1);
            else                  checkOutput("C delivered payload", 32'(cOutData), 32'(cExp.pop_front()));
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {aInValid, aOutReady, aHold, aFlush} = '0;
        {bInValid, bOutReady, bHold, bFlush} = '0;
        {cInValid, cOutReady, cHold, cFlush} = '0;
        {dInValid, dOutReady, dHold, dFlush} = '0;
        aInData = '0; bInData = '0; cInData = '0; dInData = '0;

        // Reset state.
        applyStimulus();
        applyStimulus();
        checkOutput("A in_ready during reset", 32'(aInReady), 0);
        checkOutput("C in_ready during reset", 32'(cInReady), 0);
        checkOutput("A out_valid in reset", 32'(aOutValid), 0);
        checkOutput("A out_data in reset", 32'(aOutData), 32'(BUBBLE));
        checkOutput("A occupancy in reset", 32'(aOcc), 0);
        reset = 1'b0;
        #1;
        checkOutput("A in_ready after reset", 32'(aInReady), 1);
        checkOutput("B in_ready after reset", 32'(bInReady), 1);

        // A: three back-to-back pushes, DEPTH=3 latency, peak occupancy.
        aOutReady = 1'b1;
        aInValid  = 1'b1;
        aInData   = 16'h0011; aExp.push_back(16'h0011);
        applyStimulus();
        checkOutput("A occupancy after first push", 32'(aOcc), 1);
        checkOutput("A in_ready streaming", 32'(aInReady), 1);
        aInData   = 16'h0022; aExp.push_back(16'h0022);
        applyStimulus();
        checkOutput("A out_valid before latency", 32'(aOutValid), 0);
        aInData   = 16'h0033; aExp.push_back(16'h0033);
        applyStimulus();
        checkOutput("A out_valid at latency", 32'(aOutValid), 1);
        checkOutput("A occupancy peak", 32'(aOcc), 3);
        aInValid  = 1'b0;
        applyStimulus();
        checkOutput("A out_valid second beat", 32'(aOutValid), 1);
        applyStimulus();
        checkOutput("A out_valid third beat", 32'(aOutValid), 1);
        applyStimulus();
        checkOutput("A occupancy drained", 32'(aOcc), 0);

        // B: skid fill with downstream stalled, then drain without gaps.
        bOutReady = 1'b0;
        bInValid  = 1'b1;
        bInData   = 16'h000A; bExp.push_back(16'h000A);
        applyStimulus();
        checkOutput("B occupancy one", 32'(bOcc), 1);
        checkOutput("B in_ready with main full", 32'(bInReady), 1);
        bInData   = 16'h000B; bExp.push_back(16'h000B);
        applyStimulus();
        checkOutput("B in_ready with skid full", 32'(bInReady), 0);
        checkOutput("B occupancy full", 32'(bOcc), 2);
        checkOutput("B out_data head", 32'(bOutData), 32'h000A);
        bInData   = 16'h000C;
        applyStimulus();
        checkOutput("B occupancy stalled", 32'(bOcc), 2);
        checkOutput("B in_ready stalled", 32'(bInReady), 0);
        bOutReady = 1'b1;
        applyStimulus();
        checkOutput("B in_ready after skid drain", 32'(bInReady), 1);
        checkOutput("B occupancy after first pop", 32'(bOcc), 1);
        checkOutput("B out_valid no gap 1", 32'(bOutValid), 1);
        bExp.push_back(16'h000C);
        applyStimulus();
        bInValid  = 1'b0;
        checkOutput("B occupancy push+pop", 32'(bOcc), 1);
        checkOutput("B out_valid no gap 2", 32'(bOutValid), 1);
        applyStimulus();
        checkOutput("B occupancy drained", 32'(bOcc), 0);
        bOutReady = 1'b0;

        // C: hold for three edges with traffic offered on both sides.
        cOutReady = 1'b1;
        cInValid  = 1'b1;
        cInData   = 16'h0101; cExp.push_back(16'h0101);
        applyStimulus();
        cInData   = 16'h0202; cExp.push_back(16'h0202);
        applyStimulus();
        checkOutput("C occupancy before hold", 32'(cOcc), 2);
        cHold     = 1'b1;
        cInData   = 16'h0303;
        #1;
        checkOutput("C in_ready in hold", 32'(cInReady), 0);
        checkOutput("C out_valid in hold", 32'(cOutValid), 0);
        checkOutput("C out_data in hold", 32'(cOutData), 32'(BUBBLE));
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("C occupancy during hold", 32'(cOcc), 2);
        end
        cHold     = 1'b0;
        cExp.push_back(16'h0303);
        applyStimulus();
        checkOutput("C occupancy after resume", 32'(cOcc), 2);
        cInData   = 16'h0404; cExp.push_back(16'h0404);
        applyStimulus();
        cInValid  = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("C occupancy drained", 32'(cOcc), 0);

        // C: fill with downstream stalled, ready follows out_ready when full.
        cOutReady = 1'b0;
        cInValid  = 1'b1;
        cInData   = 16'h0505; cExp.push_back(16'h0505);
        applyStimulus();
        cInData   = 16'h0606; cExp.push_back(16'h0606);
        applyStimulus();
        checkOutput("C occupancy full", 32'(cOcc), 2);
        cInData   = 16'h0707;
        #1;
        checkOutput("C in_ready full, out_ready=0", 32'(cInReady), 0);
        cOutReady = 1'b1;
        #1;
        checkOutput("C in_ready full, out_ready=1", 32'(cInReady), 1);

        // C: flush while full with traffic offered.
        cFlush    = 1'b1;
        cExp.delete();
        #1;
        checkOutput("C in_ready in flush", 32'(cInReady), 0);
        checkOutput("C out_valid in flush", 32'(cOutValid), 0);
        applyStimulus();
        cFlush    = 1'b0;
        cInValid  = 1'b0;
        checkOutput("C occupancy after flush", 32'(cOcc), 0);
        checkOutput("C out_valid after flush", 32'(cOutValid), 0);
        checkOutput("C out_data after flush", 32'(cOutData), 32'(BUBBLE));
        applyStimulus();
        checkOutput("C flush input not accepted", 32'(cOcc), 0);
        cOutReady = 1'b0;

        // A: asynchronous reset mid-cycle with two payloads in flight.
        aOutReady = 1'b0;
        aInValid  = 1'b1;
        aInData   = 16'h0A0A; aExp.push_back(16'h0A0A);
        applyStimulus();
        aInData   = 16'h0B0B; aExp.push_back(16'h0B0B);
        applyStimulus();
        aInValid  = 1'b0;
        applyStimulus();
        checkOutput("A out_valid before reset", 32'(aOutValid), 1);
        checkOutput("A occupancy before reset", 32'(aOcc), 2);
        #2;
        reset = 1'b1;
        aExp.delete();
        #1;
        checkOutput("A out_valid on async reset", 32'(aOutValid), 0);
        checkOutput("A out_data on async reset", 32'(aOutData), 32'(BUBBLE));
        checkOutput("A occupancy on async reset", 32'(aOcc), 0);
        checkOutput("A in_ready on async reset", 32'(aInReady), 0);
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("A in_ready after release", 32'(aInReady), 1);
        aOutReady = 1'b1;
        aInValid  = 1'b1;
        aInData   = 16'h0055; aExp.push_back(16'h0055);
        applyStimulus();
        aInValid  = 1'b0;
        checkOutput("A out_valid 1 edge after push", 32'(aOutValid), 0);
        applyStimulus();
        checkOutput("A out_valid 2 edges after push", 32'(aOutValid), 0);
        applyStimulus();
        checkOutput("A out_valid 3 edges after push", 32'(aOutValid), 1);
        applyStimulus();
        applyStimulus();

        // D: bypass mirrors the handshake combinationally.
        dInValid = 1'b1;
        dInData  = 16'hDEAD;
        for (int k = 0; k < 4; k++) begin
            dOutReady = k[0];
            #1;
            checkOutput("D out_valid mirrors in_valid", 32'(dOutValid), 1);
            checkOutput("D out_data mirrors in_data", 32'(dOutData), 32'hDEAD);
            checkOutput("D in_ready mirrors out_ready", 32'(dInReady), 32'(k % 2));
            checkOutput("D occupancy", 32'(dOcc), 0);
        end
        dInValid = 1'b0;
        #1;
        checkOutput("D out_valid idle", 32'(dOutValid), 0);
        checkOutput("D out_data idle bubble", 32'(dOutData), 32'(BUBBLE));

        // Every expected payload must have been delivered.
        applyStimulus();
        checkOutput("A scoreboard drained", 32'(aExp.size()), 0);
        checkOutput("B scoreboard drained", 32'(bExp.size()), 0);
        checkOutput("C scoreboard drained", 32'(cExp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
